// File: rtl/text_render.sv
// Character-cell text overlay: 80x30 character buffer, font ROM addressing, 3-cycle pixel/sync pipeline.
// Optional blinking cursor cell when TEXT_CURSOR_EN is defined.
module text_render #(
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [6:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [6:0]  wr_char,
    input  logic        clear_req,
    output logic        busy,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
`ifdef TEXT_CURSOR_EN
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
`endif
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned IDX_W  = 12;
    localparam int unsigned CHAR_W = 7;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [CHAR_W-1:0] SPACE_CHAR = 7'h20;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

    // Clear sequencer state register; reset always (re)starts a full clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = S_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + IDX_W'(1);
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state == S_CLEAR);

    logic [IDX_W-1:0]  wr_idx, rd_idx, rd_safe, mem_wa;
    logic [CHAR_W-1:0] mem_wd;
    logic              ext_wr, mem_we;

    // row*80 + col as shift-add
    assign wr_idx = (IDX_W'(wr_row) << 6) + (IDX_W'(wr_row) << 4) + IDX_W'(wr_col);
    assign rd_idx = (IDX_W'(pix_y[9:4]) << 6) + (IDX_W'(pix_y[9:4]) << 4) + IDX_W'(pix_x[9:3]);
    assign rd_safe = (rd_idx < IDX_W'(CELLS)) ? rd_idx : '0;

    assign ext_wr = wr_en && !busy && (wr_col < 7'(COLS)) && (wr_row < 5'(ROWS));
    assign mem_we = rst_n && (busy || ext_wr);
    assign mem_wa = busy ? clr_cnt : wr_idx;
    assign mem_wd = busy ? SPACE_CHAR : wr_char;

    logic [CHAR_W-1:0] char_mem [CELLS];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            char_mem[mem_wa] <= mem_wd;
        end
    end

    logic [CHAR_W-1:0] char_q;
    logic [2:0]        x_d1, x_d2;
    logic [3:0]        y_d1;
    logic              von_d1, von_d2, hs_d1, hs_d2, vs_d1, vs_d2;
    logic              invert;

    // Stage 1: registered character read plus aligned coordinates/flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_q <= '0;
            x_d1   <= '0;
            y_d1   <= '0;
            von_d1 <= 1'b0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
        end else begin
            char_q <= char_mem[rd_safe];
            x_d1   <= pix_x[2:0];
            y_d1   <= pix_y[3:0];
            von_d1 <= video_on;
            hs_d1  <= hsync_in;
            vs_d1  <= vsync_in;
        end
    end

    assign font_addr = {char_q, y_d1};

    // Stage 2: aligned with the font ROM's registered row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_d2   <= '0;
            von_d2 <= 1'b0;
            hs_d2  <= 1'b0;
            vs_d2  <= 1'b0;
        end else begin
            x_d2   <= x_d1;
            von_d2 <= von_d1;
            hs_d2  <= hs_d1;
            vs_d2  <= vs_d1;
        end
    end

`ifdef TEXT_CURSOR_EN
    logic [6:0] col_d1, col_d2;
    logic [4:0] row_d1, row_d2;
    logic [5:0] frame_cnt;
    logic       vs_prev;

    // Cell coordinates ride alongside the pixel pipeline; frame counter drives the blink.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_d1    <= '0;
            col_d2    <= '0;
            row_d1    <= '0;
            row_d2    <= '0;
            frame_cnt <= '0;
            vs_prev   <= 1'b0;
        end else begin
            col_d1  <= pix_x[9:3];
            col_d2  <= col_d1;
            row_d1  <= pix_y[8:4];
            row_d2  <= row_d1;
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign invert = frame_cnt[5] && (col_d2 == cursor_col) && (row_d2 == cursor_row);
`else
    assign invert = 1'b0;
`endif

    // Stage 3: pixel select and colour mux.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsync_out <= hs_d2;
            vsync_out <= vs_d2;
            if (!von_d2) begin
                rgb <= '0;
            end else if (font_data[3'd7 - x_d2] ^ invert) begin
                rgb <= FG_RGB;
            end else begin
                rgb <= BG_RGB;
            end
        end
    end

endmodule

// File: tb/tb_text_render.sv
// Randomized self-checking bench for text_render against a cell-array reference model.
module tb_text_render;

    localparam logic [11:0] FG = 12'hF80;
    localparam logic [11:0] BG = 12'h00F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_col = '0;
    logic [4:0]  wr_row = '0;
    logic [6:0]  wr_char = '0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cur_col = 7'd127;
    logic [4:0]  cur_row = 5'd0;
`endif

    text_render #(.FG_RGB(FG), .BG_RGB(BG)) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_col(wr_col),
        .wr_row(wr_row), .wr_char(wr_char), .clear_req(clear_req), .busy(busy),
        .font_addr(font_addr), .font_data(font_data),
`ifdef TEXT_CURSOR_EN
        .cursor_col(cur_col), .cursor_row(cur_row),
`endif
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [10:0] a);
        if (a[10:4] == 7'h20) return 8'h00;
        if (a[10:4] == 7'h41) return 8'h81;
        return 8'(a * 11'd73) ^ 8'(a[10:4]);
    endfunction

    // Font ROM with one registered cycle of latency.
    always @(posedge clk) font_data <= rom(font_addr);

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fchk;
        logic [10:0] fa;
    } exp_t;

    exp_t        q[$];
    logic [6:0]  ref_mem [2400];
    int          busy_left = 0;
    int          frames = 0;
    logic        vs_prev_m = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs of the last edge, drive new inputs, advance the model.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic von,
                        input logic hs, input logic vs, input logic we,
                        input logic [6:0] wc, input logic [4:0] wr, input logic [6:0] wch,
                        input logic clr);
        exp_t       e;
        int         idx;
        logic [6:0] ch;
        logic [7:0] fd;
        logic       b, inv;
        if (rst_n) begin
            check("busy", 32'(busy), 32'(busy_left > 0));
            if (q.size() > 0 && q[$].fchk) check("font_addr", 32'(font_addr), 32'(q[$].fa));
            if (q.size() == 3) begin
                e = q.pop_front();
                check("rgb", 32'(rgb), 32'(e.rgb));
                check("hsync_out", 32'(hsync_out), 32'(e.hs));
                check("vsync_out", 32'(vsync_out), 32'(e.vs));
            end
        end
        pix_x = x; pix_y = y; video_on = von; hsync_in = hs; vsync_in = vs;
        wr_en = we; wr_col = wc; wr_row = wr; wr_char = wch; clear_req = clr;
        if (rst_n) begin
            idx = int'(y[9:4]) * 80 + int'(x[9:3]);
            ch  = (idx < 2400) ? ref_mem[idx] : 7'd0;
            e.fa   = {ch, y[3:0]};
            e.fchk = von && (idx < 2400);
            fd  = rom(e.fa);
            b   = fd[3'd7 - x[2:0]];
            inv = 1'b0;
`ifdef TEXT_CURSOR_EN
            inv = (((frames >> 5) & 1) == 1) && (x[9:3] == cur_col) && (y[8:4] == cur_row);
`endif
            e.rgb = !von ? 12'h000 : ((b ^ inv) ? FG : BG);
            e.hs  = hs;
            e.vs  = vs;
            q.push_back(e);
            if (busy_left > 0) begin
                ref_mem[2400 - busy_left] = 7'h20;
                busy_left--;
            end else begin
                if (we && wc < 7'd80 && wr < 5'd30) ref_mem[int'(wr) * 80 + int'(wc)] = wch;
                if (clr) busy_left = 2400;
            end
            if (vs && !vs_prev_m) frames++;
            vs_prev_m = vs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        exp_t z;
        z.rgb = '0; z.hs = 1'b0; z.vs = 1'b0; z.fchk = 1'b0; z.fa = '0;
        rst_n = 1'b0;
        repeat (n) step(10'd9, 10'd9, 1'b1, 1'b1, 1'b1, 1'b1, 7'd3, 5'd3, 7'h11, 1'b1);
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync_out), 32'h0);
        check("rst_vsync", 32'(vsync_out), 32'h0);
        check("rst_font_addr", 32'(font_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        q.delete();
        repeat (3) q.push_back(z);
        busy_left = 2400;
        frames = 0;
        vs_prev_m = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            idle();
            cnt++;
        end
    endtask

    task automatic scan_cell(input int c, input int r);
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 8; xx += 3)
                step(10'(c * 8 + xx), 10'(r * 16 + yy), 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);
    endtask

    initial begin
        int cnt;
        int lc, lr;
        logic [9:0] rx, ry;
        logic [6:0] wc;
        logic [4:0] wr;
        for (int i = 0; i < 2400; i++) ref_mem[i] = 7'h00;

        do_reset(4);
        wait_idle(cnt);
        check("busy_len_reset", 32'(cnt), 32'd2400);

        // every cell holds a space after the power-on clear
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                step(10'(c * 8 + $urandom_range(7)), 10'(r * 16 + $urandom_range(15)), 1'b1,
                     1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);
        for (int xx = 0; xx < 640; xx++)
            step(10'(xx), 10'($urandom_range(15)), 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);

        // 'A' at col 5, row 2
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd5, 5'd2, 7'h41, 1'b0);
        for (int yy = 32; yy < 48; yy++)
            for (int xx = 40; xx < 48; xx++)
                step(10'(xx), 10'(yy), 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);

        // out-of-range writes, then a write issued late in a clear
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd80, 5'd3, 7'h55, 1'b0);
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 5'd30, 7'h56, 1'b0);
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b1);
        cnt = 0;
        while (busy_left > 50 && cnt < 3000) begin idle(); cnt++; end
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 5'd0, 7'h57, 1'b0);
        wait_idle(cnt);
        check("busy_len_tail", 32'(cnt), 32'd49);
        scan_cell(0, 4);
        scan_cell(1, 0);
        scan_cell(5, 2);

        // blanking with toggling syncs
        for (int i = 0; i < 40; i++)
            step(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b0,
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);

        // random traffic with one clear in the middle
        lc = 5; lr = 2;
        for (int i = 0; i < 3000; i++) begin
            rx = 10'($urandom_range(639));
            ry = 10'($urandom_range(479));
            if ($urandom_range(1) == 1) begin
                rx = 10'(lc * 8 + $urandom_range(7));
                ry = 10'(lr * 16 + $urandom_range(15));
            end
            wc = 7'($urandom_range(85));
            wr = 5'($urandom_range(31));
            if (wc < 7'd80 && wr < 5'd30 && $urandom_range(3) == 0) begin
                lc = int'(wc); lr = int'(wr);
            end
            step(rx, ry, 1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(2) == 0), wc, wr, 7'($urandom), 1'(i == 1500));
        end
        wait_idle(cnt);

        // reset at clear index 1000 restarts the clear
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 7'd0, 1'b1);
        cnt = 0;
        while (busy_left > 1400 && cnt < 3000) begin idle(); cnt++; end
        do_reset(3);
        wait_idle(cnt);
        check("busy_len_midreset", 32'(cnt), 32'd2400);
        scan_cell(7, 12);

`ifdef TEXT_CURSOR_EN
        cur_col = 7'd0; cur_row = 5'd0;
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 5'd0, 7'h41, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 5'd0, 7'd0, 1'b0);
                idle();
            end
            scan_cell(0, 0);
            scan_cell(1, 0);
        end
`endif

        repeat (4) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/text_render.md
# text_render

Character-cell text overlay stage for the 640x480 VGA path. Takes the pixel coordinates from the sync generator, looks up the character code in an internal 80x30 character buffer, and drives the address of the downstream 8x16 font ROM (11-bit address, 8-bit row, one registered cycle of read latency). It then picks the addressed pixel bit out of the returned font row and outputs aligned RGB and sync. Game logic writes characters through a simple write port. A clear sequencer fills the buffer with spaces.

## Interface
- `FG_RGB`, default 12'hFFF: foreground colour for glyph pixels.
- `BG_RGB`, default 12'h000: background colour inside the active video area.
- `clk`  in  1: pixel clock, the single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `pix_x`  in  10: current pixel column, 0..639 when active.
- `pix_y`  in  10: current pixel row, 0..479 when active.
- `video_on`  in  1: active-area flag.
- `hsync_in`, `vsync_in`  in  1: raw syncs.
- `wr_en`  in  1: character write strobe.
- `wr_col`  in  7: target column, 0..79.
- `wr_row`  in  5: target row, 0..29.
- `wr_char`  in  7: character code.
- `clear_req`  in  1: one-cycle pulse that starts a buffer clear.
- `busy`  out  1: high while a clear is in progress.
- `font_addr`  out  11: font ROM address, `{char[6:0], pix_y[3:0]}`.
- `font_data`  in  8: font ROM row. Bit 7 is the leftmost pixel; valid one cycle after `font_addr`.
- `rgb`  out  12: output colour.
- `hsync_out`, `vsync_out`  out  1: syncs delayed to match `rgb`.

## Operation
- **Character buffer**
  - 2400 x 7-bit synchronous RAM.
  - Index = row*80 + col, computed as (row<<6)+(row<<4)+col.
  - One write port and one registered read port.
- **Read address** = `pix_y[8:4]`*80 + `pix_x[9:3]`. When `video_on`=0, the address is don't-care and the result is masked.
- **External writes**
  - A write is taken when `wr_en`=1, `busy`=0, `wr_col`<80 and `wr_row`<30.
  - Out-of-range writes are dropped silently.
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE→CLEAR on `clear_req`.
  - In CLEAR, one cell per cycle is written with 7'h20, using a 12-bit counter from 0 to 2399.
  - CLEAR→IDLE on the cycle after index 2399 is written.
  - `busy`=1 exactly while in CLEAR.
  - In CLEAR, `clear_req` and `wr_en` are ignored.
- **Reset**
  - Forces CLEAR with the counter at 0, so the buffer is always initialised after reset.
  - Reset asserted mid-clear restarts the clear from 0.
- **Reads during CLEAR** continue normally; display shows partially cleared contents.
- **Pixel select**: `font_data[7 - x_d2[2:0]]`, where `x_d2` is `pix_x` delayed 2 cycles.
- **Output**: `rgb` = FG_RGB if the selected bit is 1, BG_RGB if 0; forced to 0 when delayed `video_on`=0.

## Timing
- Cycle N: `pix_x`, `pix_y`, `video_on` and syncs are presented.
- Edge N+1:
  - Character RAM output is registered.
  - `y_d1`, `x_d1` and the delayed flags are registered.
  - `font_addr` = `{char_q, y_d1[3:0]}`, combinational from stage-1 registers only.
- Edge N+2: the font ROM registers `font_data`; `x_d2` and the flags are registered.
- Edge N+3: `rgb`, `hsync_out` and `vsync_out` are registered. Total latency is 3 cycles, identical for colour and sync.
- Write/read interaction:
  - A write at edge W is visible to reads issued in cycle W+1 onward.
  - A simultaneous read of the same cell returns the old data.
- Clear timing: `busy` rises on the edge after `clear_req` and stays high exactly 2400 cycles. After reset release, `busy` is high for 2400 cycles.
- Reset values: `rgb`=0, `hsync_out`=0, `vsync_out`=0, `font_addr`=0, `busy`=1. All pipeline registers are cleared.

## Configuration
- **Macro `TEXT_CURSOR_EN`**
- **When defined**, the block adds:
  - Inputs `cursor_col` (7 bits) and `cursor_row` (5 bits).
  - A 6-bit frame counter that increments on each `vsync_in` rising edge (edge detector register, reset to 0).
  - Cursor inversion: while counter bit 5 = 1, pixels in the cursor cell swap FG and BG. The match is done on the delayed cell coordinates, with no added latency.
- **When undefined**: no cursor ports, no counter, no inversion.

## Test plan
- **Reset and clear**: release reset → `busy` high for exactly 2400 cycles; afterwards every cell reads 0x20, and a scan of row 0 gives all-BG output.
- **Write then display**:
  - Stimulus: write char 0x41 at col 5, row 2; scan `pix_x`=40..47, `pix_y`=32..47. ROM model returns row pattern 8'b1000_0001.
  - Expected: `font_addr`=`{7'h41, y[3:0]}` one cycle after input; `rgb`=FG at x=40 and x=47, BG elsewhere, 3 cycles after input.
- **Out-of-range and busy writes**: `wr_col`=80, and a write issued while `busy`=1 → neither write changes any cell.
- **Latency and blanking**: toggle `hsync_in`/`vsync_in` with `video_on`=0 → syncs reappear 3 cycles later; `rgb`=0 throughout.
- **Reset mid-clear**: assert `rst_n`=0 at clear index 1000, release → `busy` lasts a further 2400 cycles.
- **Cursor (macro defined)**: cursor at (0,0); after 32 `vsync_in` rising edges → cell (0,0) pixels inverted; after 64 edges → normal.
